// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline constants, fetch-state enum and J-immediate helper
package pipeline_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [6:0]  OPC_JAL   = 7'b1101111;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } fetch_state_e;

  // Sign-extended J-type immediate; the decoder uses the same extraction.
  function automatic logic [31:0] j_imm(input logic [31:0] w);
    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/if_jal_predecode.sv
// rtl/if_jal_predecode.sv - combinational JAL detect and target for fetch-time prediction
module if_jal_predecode
  import pipeline_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] pc,
  output logic        is_jal,
  output logic [31:0] target
);

  assign is_jal = (word[6:0] == OPC_JAL);
  assign target = pc + j_imm(word);

endmodule

// File: rtl/if_id_fetch_stage.sv
// rtl/if_id_fetch_stage.sv - PC, single-outstanding imem fetch and IF/ID register
// Optional fetch-time JAL prediction under IF_JAL_PREDICT_EN.
module if_id_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ID_stall,
  input  logic        EX_redirect,
  input  logic [31:0] EX_redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        IF_ID_valid,
  output logic [31:0] IF_ID_instr,
  output logic [31:0] IF_ID_pc,
  output logic        IF_ID_take
);
  import pipeline_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  buf_q, buf_d;
  logic         kill_q, kill_d;
  logic         valid_q, valid_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  id_pc_q, id_pc_d;
  logic         take_q, take_d;

  logic         accept;
  logic [31:0]  accept_word;
  logic [31:0]  redirect_target;
  logic [31:0]  next_pc;
  logic         next_take;

  assign redirect_target = {EX_redirect_pc[31:2], 2'b00};
  assign accept_word     = (state_q == S_FULL) ? buf_q : imem_rdata;

`ifdef IF_JAL_PREDICT_EN
  logic        is_jal;
  logic [31:0] jal_target;

  if_jal_predecode u_predecode (
    .word   (accept_word),
    .pc     (pc_q),
    .is_jal (is_jal),
    .target (jal_target)
  );

  assign next_pc   = is_jal ? jal_target : pc_q + 32'd4;
  assign next_take = is_jal;
`else
  assign next_pc   = pc_q + 32'd4;
  assign next_take = 1'b0;
`endif

  assign imem_req  = (state_q == S_REQ) && !EX_redirect;
  assign imem_addr = pc_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    kill_d  = kill_q;
    accept  = 1'b0;
    case (state_q)
      S_REQ: begin
        if (EX_redirect) begin
          pc_d = redirect_target;
        end else if (imem_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          // A response arriving under a redirect (now or earlier) belongs to the old path.
          if (kill_q || EX_redirect) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
            if (EX_redirect) pc_d = redirect_target;
          end else if (!ID_stall) begin
            accept  = 1'b1;
            state_d = S_REQ;
          end else begin
            buf_d   = imem_rdata;
            state_d = S_FULL;
          end
        end else if (EX_redirect) begin
          kill_d = 1'b1;
          pc_d   = redirect_target;
        end
      end
      S_FULL: begin
        if (EX_redirect) begin
          pc_d    = redirect_target;
          state_d = S_REQ;
        end else if (!ID_stall) begin
          accept  = 1'b1;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
    if (accept) pc_d = next_pc;
  end

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    id_pc_d = id_pc_q;
    take_d  = take_q;
    if (EX_redirect) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      take_d  = 1'b0;
    end else if (!ID_stall) begin
      if (accept) begin
        valid_d = 1'b1;
        instr_d = accept_word;
        id_pc_d = pc_q;
        take_d  = next_take;
      end else begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
        take_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      buf_q   <= 32'd0;
      kill_q  <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      id_pc_q <= 32'd0;
      take_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      kill_q  <= kill_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      id_pc_q <= id_pc_d;
      take_q  <= take_d;
    end
  end

  assign IF_ID_valid = valid_q;
  assign IF_ID_instr = instr_q;
  assign IF_ID_pc    = id_pc_q;
  assign IF_ID_take  = take_q;

endmodule

// File: doc/if_id_fetch_stage.md
Name: if_id_fetch_stage

Overview:
- Fetch stage plus IF/ID pipeline register of the 5-stage RISC-V core; feeds the decoder, whose outputs load the ID/EX register.
- Owns the PC and drives a single-outstanding req/gnt/rvalid instruction-memory handshake.
- Buffers one returned instruction while decode is stalled.
- Flushes and kills stale fetches on EX-stage redirects (taken branch, jump).

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction emitted on bubbles (addi x0,x0,0).

Ports:
- clk  in  1  clock
- reset  in  1  reset (asynchronous, active-high)
- ID_stall  in  1  hazard unit holds IF/ID (load-use stall)
- EX_redirect  in  1  EX resolved taken branch/jump; flush and refetch
- EX_redirect_pc  in  32  redirect target
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address; always equals pc
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  read data valid; at least 1 cycle after gnt
- imem_rdata  in  32  instruction word
- IF_ID_valid  out  1  IF/ID holds a real instruction
- IF_ID_instr  out  32  instruction to decode
- IF_ID_pc  out  32  PC of IF_ID_instr
- IF_ID_take  out  1  fetch predicted taken (feeds ID_take)

Behaviour:
- Reset values: pc=RESET_PC; state=S_REQ; kill=0; buf=0; IF_ID_valid=0; IF_ID_instr=NOP_INSTR; IF_ID_pc=0; IF_ID_take=0.
- imem_req = (state==S_REQ) && !EX_redirect. imem_addr = pc.
- EX_redirect forces a target of {EX_redirect_pc[31:2],2'b00}.
- States and transitions:
  - S_REQ: redirect -> pc<=target, stay. Else gnt -> S_WAIT.
  - S_WAIT: rvalid arrives.
    - rvalid with kill or EX_redirect -> discard, kill<=0, S_REQ.
    - rvalid, no kill, !ID_stall -> accept; S_REQ.
    - rvalid, no kill, ID_stall -> buf<=rdata, S_FULL.
    - EX_redirect without rvalid -> kill<=1, pc<=target, stay.
  - S_FULL: EX_redirect -> drop buf, pc<=target, S_REQ. Else !ID_stall -> accept buf, S_REQ. Else hold.
- Accept (word w at pc):
  - IF_ID_valid<=1, IF_ID_instr<=w, IF_ID_pc<=pc, IF_ID_take<=0.
  - pc<=pc+4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- IF/ID register update, priority order:
  1. EX_redirect: flush — valid<=0, instr<=NOP_INSTR, take<=0. Flush overrides ID_stall.
  2. ID_stall: hold all IF_ID_*.
  3. Otherwise: accept, or bubble when nothing was delivered (valid<=0, instr<=NOP, take<=0, pc field held).
- Fetch-to-IF_ID latency:
  - Zero-wait memory (gnt in S_REQ, rvalid next cycle): 2 cycles per instruction.
  - Throughput: one instruction per 2 cycles. No deeper pipelining; at most one request outstanding.
- Reset mid-transaction clears state immediately. A late rvalid for a pre-reset request is a memory-side violation; the memory must also be reset.

Optional Feature:
- Macro: IF_JAL_PREDICT_EN.
- With it: on accept, if w[6:0]==7'b1101111 (JAL):
  - pc<=pc + sext({w[31],w[19:12],w[20],w[30:21],1'b0}), modulo 2^32.
  - IF_ID_take<=1.
  - EX must then skip the redirect for JAL entries with take=1.
- Without it: IF_ID_take is constant 0 and pc always advances by 4.

Decomposition:
- Shared package (pipeline_pkg):
  - NOP_INSTR value.
  - OPC_JAL constant.
  - Fetch-state enum (S_REQ/S_WAIT/S_FULL).
  - J-immediate extraction function, shared with the decoder.
- One natural sub-module: if_jal_predecode.
  - Combinational: word, pc -> is_jal, target.
  - Instantiated only under IF_JAL_PREDICT_EN.

Test Plan:
- Reset then zero-wait memory returning 0x00100093 at 0x0, 0x00200113 at 0x4 -> IF_ID_pc 0x0 then 0x4, each valid 2 cycles apart; first IF_ID_valid 2 cycles after reset release.
- ID_stall high 3 cycles while rvalid arrives with 0x00A00193 at 0x8 -> S_FULL, IF_ID unchanged; the cycle after stall drops IF_ID_instr=0x00A00193, IF_ID_pc=0x8; no imem_req during stall.
- EX_redirect to 0x103 in S_WAIT with rvalid 2 cycles later -> response discarded, next imem_addr=0x100, IF_ID_valid=0, IF_ID_instr=0x00000013.
- EX_redirect and ID_stall asserted together in S_FULL -> flush wins, buf dropped, next request at target.
- pc=0xFFFF_FFFC, instruction accepted -> next imem_addr=0x0.
- IF_JAL_PREDICT_EN defined, 0x0080006F (jal x0,8) fetched at 0x20 -> IF_ID_take=1, next imem_addr=0x28. Undefined: IF_ID_take=0, next addr 0x24.
